// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM encoding, bus widths and stall-vector polarity.
package if_fetch_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_addr_t ZERO_WORD = 32'h0000_0000;
  localparam inst_addr_t PC_STEP   = 32'd4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam inst_t NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10,
    S_KILL = 2'b11
  } fetch_state_e;

  function automatic inst_addr_t word_align(
    input inst_addr_t a
  );
    return {a[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC owner, req/ack ibus master and
// redirect handling feeding the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter inst_t      NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  inst_addr_t fetch_pc;
  inst_addr_t redirect_pc;
  inst_addr_t next_addr;
  logic       pending_redirect;
  logic       hold;
  logic       ack_hit;
  logic       redirect;
  logic       unused_stall;

  assign unused_stall = ^stall[5:1];
  assign hold         = (stall[0] == STOP);
  assign redirect     = flush | branch_flag_i;
  assign ack_hit      = ibus_req_o & ibus_ack_i;

  always_comb begin
    next_addr = fetch_pc + PC_STEP;
    if (flush) begin
      next_addr = new_pc;
    end else if (branch_flag_i) begin
      next_addr = branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (ack_hit) begin
          if (!flush && hold) begin
            state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          state_nxt = S_KILL;
        end
      end
      S_HOLD: begin
        if (flush || !hold) begin
          state_nxt = S_REQ;
        end
      end
      S_KILL: begin
        if (ack_hit) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ibus_req_o  = (state == S_REQ) || (state == S_KILL);
    ibus_addr_o = word_align(fetch_pc);
    // Must stay independent of stall[] to avoid a loop
    stallreq_from_if = (state == S_IDLE)
                     || pending_redirect
                     || ((state == S_REQ) && !ibus_ack_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_pc         <= RESET_PC;
      redirect_pc      <= ZERO_WORD;
      pending_redirect <= 1'b0;
      if_pc            <= ZERO_WORD;
      if_inst          <= NOP_INST;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (flush) begin
            fetch_pc <= new_pc;
          end
        end
        S_REQ: begin
          if (ack_hit) begin
            if (flush) begin
              fetch_pc <= new_pc;
            end else begin
              if_pc   <= ibus_addr_o;
              if_inst <= ibus_rdata_i;
              if (!hold) begin
                fetch_pc <= next_addr;
              end
            end
          end else if (redirect) begin
            redirect_pc      <= next_addr;
            pending_redirect <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush) begin
            fetch_pc <= new_pc;
          end else if (!hold) begin
            fetch_pc <= next_addr;
          end
        end
        S_KILL: begin
          if (flush) begin
            redirect_pc <= new_pc;
          end
          // Stale reply is dropped; resume at the latest redirect
          if (ack_hit) begin
            fetch_pc         <= flush ? new_pc : redirect_pc;
            pending_redirect <= 1'b0;
          end
        end
        default: ;
      endcase
      if (flush) begin
        if_pc   <= ZERO_WORD;
        if_inst <= NOP_INST;
      end
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests on the instruction bus using a req/ack handshake with variable latency.
- Presents a matched if_pc/if_inst pair to IF/ID and applies redirects from branches (ID) and exceptions (flush).
- Raises a stall request to the pipeline controller while an instruction is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NOP_INST, 32'h0000_0000, instruction word driven when no valid fetch data is held.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- stall  in  6  pipeline stall vector; only stall[0] (PC hold) is used here; 1 = Stop.
- flush  in  1  exception flush; highest-priority redirect.
- new_pc  in  32  exception handler address, valid when flush=1.
- branch_flag_i  in  1  taken branch from ID.
- branch_target_i  in  32  branch target, valid when branch_flag_i=1.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address; word-aligned; held stable while req=1 and ack=0.
- ibus_ack_i  in  1  data valid for the current request; sampled only when req=1.
- ibus_rdata_i  in  32  instruction word, valid when ack=1.
- if_pc  out  32  address of if_inst.
- if_inst  out  32  fetched instruction sent to IF/ID.
- stallreq_from_if  out  1  asks the controller to stall while no fresh instruction is available.

Behaviour:
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC.
  - if_pc=0, if_inst=NOP_INST, ibus_req_o=0.
  - pending_redirect=0, redirect_pc=0.
- States:
  - IDLE: one cycle after reset release; go to REQ with ibus_addr_o=fetch_pc.
  - REQ: ibus_req_o=1, ibus_addr_o=fetch_pc.
  - HOLD: data captured but stall[0]=1; ibus_req_o=0.
  - KILL: a redirect arrived while a request was outstanding; ibus_req_o=1 with the old address until ack, then the data is discarded.
- Next address, in priority order:
  - flush: new_pc.
  - branch_flag_i: branch_target_i.
  - otherwise: fetch_pc+4, with 32-bit wrap (FFFF_FFFC -> 0000_0000).
- REQ with ack=1 and no flush:
  - Capture: if_pc<=fetch_pc, if_inst<=ibus_rdata_i.
  - If stall[0]=0: fetch_pc<=next address and stay in REQ, issuing the new request the next cycle (back-to-back throughput of 1/cycle with zero-wait memory).
  - If stall[0]=1: go to HOLD.
  - A branch taken in the same cycle still accepts this data (delay slot); the next request goes to the target.
- REQ with ack=0:
  - flush or branch_flag_i: latch redirect_pc, go to KILL.
  - Otherwise: hold the address.
- KILL with ack=1: discard rdata, fetch_pc<=redirect_pc, go to REQ. A newer flush during KILL overwrites redirect_pc.
- HOLD:
  - When stall[0]=0: fetch_pc<=next address, go to REQ.
  - flush during HOLD: fetch_pc<=new_pc, go to REQ.
  - if_pc and if_inst stay unchanged while in HOLD.
- flush in any state:
  - if_pc<=0, if_inst<=NOP_INST in the same edge.
  - If flush coincides with ack in REQ, the returned data is dropped and the next request goes to new_pc.
- stallreq_from_if is combinational and equals 1 when:
  - state is IDLE or KILL, or
  - state is REQ and ack=0.
  - It must not depend on stall[] (avoids a combinational loop).
- Reset asserted mid-request: immediately return to reset values. A late ack arriving after reset is ignored because ack is sampled only when ibus_req_o=1.
- Address bits [1:0] are forced to 0 on ibus_addr_o.

Decomposition:
- Shared defines file:
  - RstEnable redefined to 1'b0.
  - ZeroWord, InstAddrBus [31:0], InstBus [31:0], Stop/NoStop.
  - New macros for the fetch states (2-bit encoding) and NOP_INST.
- No sub-module. Next-address selection is an inline combinational block and the FSM lives in the same file.

Test Plan:
- Reset, zero-wait memory (ack same cycle as req), stall=0 -> addresses 0,4,8,C on consecutive cycles; if_pc/if_inst pairs match memory; stallreq_from_if=0 after the first ack.
- ack delayed 3 cycles at address 0x10 -> ibus_addr_o held at 0x10 and stallreq=1 for 3 cycles; on ack, if_pc=0x10 and the next request is to 0x14.
- branch_flag_i=1, target 0x100, while a request to 0x20 is pending with ack=0 -> KILL; data for 0x20 is discarded (if_inst unchanged); the next request is to 0x100.
- branch_flag_i=1, target 0x200, in the same cycle as ack for 0x30 -> if_pc=0x30 captured (delay slot); next address 0x200.
- flush=1, new_pc=0x8000_0180, coincident with ack -> if_inst=NOP_INST, if_pc=0; next request is to 0x8000_0180.
- stall[0]=1 for 2 cycles after an ack at 0x40 -> HOLD with ibus_req_o=0 and if_pc=0x40 stable; after release, a request to 0x44. Also assert rst=0 mid-request -> all outputs return to reset values asynchronously.
